// File: rtl/pipeline_hazard_unit.sv
// Centralised hazard detection / operand forwarding control beside the ID/EX boundary.
// Optional build macro HAZARD_STATS_EN adds stall_cycles and flush_cycles event counters.
module pipeline_hazard_unit #(
    parameter int STAGES      = 3,
    parameter int ADDR_W      = 5,
    parameter int LOAD_READY  = 2,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      hold,
    input  logic                      id_valid,
    input  logic [ADDR_W-1:0]         id_rs_addr,
    input  logic [ADDR_W-1:0]         id_rt_addr,
    input  logic                      id_uses_rs,
    input  logic                      id_uses_rt,
    input  logic                      id_writes_reg,
    input  logic [ADDR_W-1:0]         id_dest_addr,
    input  logic                      id_is_load,
    input  logic                      flush,
    output logic                      stall,
    output logic [$clog2(STAGES)-1:0] ex_fwd_rs_sel,
    output logic [$clog2(STAGES)-1:0] ex_fwd_rt_sel,
    output logic                      ex_valid
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               flush_cycles
`endif
);
    localparam int SEL_W = $clog2(STAGES);

    typedef logic [STAGES-1:0][ADDR_W-1:0] dest_vec_t;

    logic [STAGES-1:0] trk_valid_q, trk_valid_d;
    logic [STAGES-1:0] trk_load_q, trk_load_d;
    dest_vec_t         trk_dest_q, trk_dest_d;
    logic [SEL_W-1:0]  rs_sel_q, rs_sel_d;
    logic [SEL_W-1:0]  rt_sel_q, rt_sel_d;
    logic              ex_valid_q, ex_valid_d;

    logic [SEL_W:0]    rs_res, rt_res;
    logic              rs_need, rt_need;
    logic [SEL_W-1:0]  rs_sel_c, rt_sel_c;
    logic              bubble;

    // Returns {needs_stall, next_select} for one source operand.
    function automatic logic [SEL_W:0] resolve_src(
        input logic [ADDR_W-1:0] src,
        input logic              used,
        input logic [STAGES-1:0] tv,
        input dest_vec_t         td,
        input logic [STAGES-1:0] tl
    );
        logic             need;
        logic [SEL_W-1:0] sel;
        need = 1'b0;
        sel  = '0;
        // Oldest-to-youngest walk lets the youngest match win; the WB entry is write-through.
        for (int j = STAGES - 2; j >= 0; j--) begin
            if (tv[j] && (td[j] == src)) begin
                need = ((j + 1) < (tl[j] ? LOAD_READY : 1));
                sel  = need ? '0 : SEL_W'(j + 1);
            end
        end
        if (!used || (src == '0)) begin
            need = 1'b0;
            sel  = '0;
        end
        return {need, sel};
    endfunction

    always_comb begin
        rs_res   = resolve_src(id_rs_addr, id_valid & id_uses_rs, trk_valid_q, trk_dest_q, trk_load_q);
        rt_res   = resolve_src(id_rt_addr, id_valid & id_uses_rt, trk_valid_q, trk_dest_q, trk_load_q);
        rs_need  = rs_res[SEL_W];
        rt_need  = rt_res[SEL_W];
        rs_sel_c = rs_res[SEL_W-1:0];
        rt_sel_c = rt_res[SEL_W-1:0];
        stall    = (rs_need | rt_need) & ~flush & ~hold;
        bubble   = flush | stall;
    end

    always_comb begin
        trk_valid_d = trk_valid_q;
        trk_load_d  = trk_load_q;
        trk_dest_d  = trk_dest_q;
        rs_sel_d    = rs_sel_q;
        rt_sel_d    = rt_sel_q;
        ex_valid_d  = ex_valid_q;
        if (!hold) begin
            trk_valid_d = {trk_valid_q[STAGES-2:0], id_valid & id_writes_reg & ~bubble};
            trk_load_d  = {trk_load_q[STAGES-2:0], id_is_load & ~bubble};
            trk_dest_d  = {trk_dest_q[STAGES-2:0], id_dest_addr};
            if (flush) begin
                for (int j = 0; j < STAGES; j++) begin
                    if (j < FLUSH_DEPTH) begin
                        trk_valid_d[j] = 1'b0;
                    end
                end
            end
            rs_sel_d   = bubble ? '0 : rs_sel_c;
            rt_sel_d   = bubble ? '0 : rt_sel_c;
            ex_valid_d = id_valid & ~bubble;
        end
    end

    // ID -> EX boundary: tracker control state and registered forwarding selects
    always_ff @(posedge clock) begin
        if (reset) begin
            trk_valid_q <= '0;
            trk_load_q  <= '0;
            rs_sel_q    <= '0;
            rt_sel_q    <= '0;
            ex_valid_q  <= 1'b0;
        end else begin
            trk_valid_q <= trk_valid_d;
            trk_load_q  <= trk_load_d;
            rs_sel_q    <= rs_sel_d;
            rt_sel_q    <= rt_sel_d;
            ex_valid_q  <= ex_valid_d;
        end
    end

    // Destination tags are qualified by the valid bits, so they carry no reset.
    always_ff @(posedge clock) begin
        trk_dest_q <= trk_dest_d;
    end

    assign ex_fwd_rs_sel = rs_sel_q;
    assign ex_fwd_rt_sel = rt_sel_q;
    assign ex_valid      = ex_valid_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
        flush_cnt_d = flush_cnt_q + {31'd0, flush & ~hold};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`endif

endmodule
